// File: rtl/sram_pkg.sv
// Shared types for the sram_nr1w family: clear-sequencer state and a lane-mask word merge.
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_init_state_t;

  localparam int SRAM_MERGE_MAX_BITS  = 512;
  localparam int SRAM_MERGE_MAX_LANES = 64;
  localparam int SRAM_BIT_IDX_W       = $clog2(SRAM_MERGE_MAX_BITS);
  localparam int SRAM_LANE_IDX_W      = $clog2(SRAM_MERGE_MAX_LANES);

  // Callers zero-extend into the fixed width and truncate the result back to their word.
  function automatic logic [SRAM_MERGE_MAX_BITS-1:0] sram_lane_merge(
    input logic [SRAM_MERGE_MAX_BITS-1:0]  old_word,
    input logic [SRAM_MERGE_MAX_BITS-1:0]  new_word,
    input logic [SRAM_MERGE_MAX_LANES-1:0] lane_mask,
    input int unsigned                     lane_width
  );
    logic [SRAM_MERGE_MAX_BITS-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < SRAM_MERGE_MAX_BITS; i++) begin
      if (lane_mask[SRAM_LANE_IDX_W'(i / lane_width)]) begin
        merged[SRAM_BIT_IDX_W'(i)] = new_word[SRAM_BIT_IDX_W'(i)];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_nr1w_if.sv
// Request/response bundle of sram_nr1w: N read ports, one byte-enabled write port, clear control.
interface sram_nr1w_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int SIZE           = 1024,
  parameter int NUM_READ_PORTS = 2,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = $clog2(SIZE)
);
  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;

  logic                                           init_start;
  logic                                           init_busy;
  logic [NUM_READ_PORTS-1:0]                      read_en;
  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]      read_addr;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]      read_data;
  logic                                           write_en;
  logic [NUM_LANES-1:0]                           write_byte_en;
  logic [ADDR_WIDTH-1:0]                          write_addr;
  logic [DATA_WIDTH-1:0]                          write_data;

  modport master (
    output init_start, read_en, read_addr, write_en, write_byte_en, write_addr, write_data,
    input  init_busy, read_data
  );

  modport slave (
    input  init_start, read_en, read_addr, write_en, write_byte_en, write_addr, write_data,
    output init_busy, read_data
  );

endinterface

// File: rtl/sram_clear_sequencer.sv
// Sweeps INIT_VALUE over every word after reset or init_start (SIZE cycles), else forwards
// the user write port with out-of-range addresses dropped; no backpressure, requests ignored while busy.
module sram_clear_sequencer
  import sram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SIZE       = 1024,
  parameter int                    BYTE_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    ADDR_WIDTH = $clog2(SIZE),
  localparam int                   NUM_LANES  = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_start,
  input  logic                  user_we,
  input  logic [NUM_LANES-1:0]  user_lane_en,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  input  logic [DATA_WIDTH-1:0] user_wdata,
  output logic                  init_busy,
  output logic                  mem_we,
  output logic [NUM_LANES-1:0]  mem_lane_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  localparam logic [ADDR_WIDTH:0]   SIZE_W   = (ADDR_WIDTH + 1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SIZE - 1);

  sram_init_state_t      state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_busy   = 1'b0;
    mem_we      = 1'b0;
    mem_lane_en = user_lane_en;
    mem_addr    = user_addr;
    mem_wdata   = user_wdata;
    case (state_q)
      CLEAR: begin
        init_busy   = 1'b1;
        mem_we      = 1'b1;
        mem_lane_en = '1;
        mem_addr    = cnt_q;
        mem_wdata   = INIT_VALUE;
        if (cnt_q == LAST_IDX) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        mem_we = user_we && ({1'b0, user_addr} < SIZE_W);
        if (init_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

endmodule

// File: rtl/sram_nr1w.sv
// N-read/1-write SRAM with built-in clear sweep; read data registered (1 cycle), no backpressure.
// SRAM_NR1W_BYPASS_EN: same-cycle read of the written word returns the merged new data.
module sram_nr1w
  import sram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    SIZE           = 1024,
  parameter int                    NUM_READ_PORTS = 2,
  parameter int                    BYTE_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
  parameter int                    ADDR_WIDTH     = $clog2(SIZE)
) (
  input  logic        clk,
  input  logic        reset,
  sram_nr1w_if.slave  bus
);

  localparam int                  NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] SIZE_W    = (ADDR_WIDTH + 1)'(SIZE);

  logic                  init_busy;
  logic                  mem_we;
  logic [NUM_LANES-1:0]  mem_lane_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_wr_word;
  logic [DATA_WIDTH-1:0] mem_q [SIZE];

  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] read_data_q, read_data_d;

  sram_clear_sequencer #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIZE       (SIZE),
    .BYTE_WIDTH (BYTE_WIDTH),
    .INIT_VALUE (INIT_VALUE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk          (clk),
    .reset        (reset),
    .init_start   (bus.init_start),
    .user_we      (bus.write_en),
    .user_lane_en (bus.write_byte_en),
    .user_addr    (bus.write_addr),
    .user_wdata   (bus.write_data),
    .init_busy    (init_busy),
    .mem_we       (mem_we),
    .mem_lane_en  (mem_lane_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata)
  );

  always_comb begin
    mem_wr_word = DATA_WIDTH'(sram_lane_merge(SRAM_MERGE_MAX_BITS'(mem_q[mem_addr]),
                                              SRAM_MERGE_MAX_BITS'(mem_wdata),
                                              SRAM_MERGE_MAX_LANES'(mem_lane_en),
                                              BYTE_WIDTH));
  end

  // Storage has no reset: a known state comes only from the clear sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wr_word;
    end
  end

  always_comb begin
    read_data_d = read_data_q;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      if (!init_busy && bus.read_en[p]) begin
        if ({1'b0, bus.read_addr[p]} < SIZE_W) begin
`ifdef SRAM_NR1W_BYPASS_EN
          if (mem_we && (mem_addr == bus.read_addr[p])) begin
            read_data_d[p] = mem_wr_word;
          end else begin
            read_data_d[p] = mem_q[bus.read_addr[p]];
          end
`else
          read_data_d[p] = mem_q[bus.read_addr[p]];
`endif
        end else begin
          read_data_d[p] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign bus.read_data = read_data_q;
  assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_sram_nr1w.sv
// Scoreboard bench for sram_nr1w (SIZE=100, 4 read ports): a word-array model predicts every
// read port and init_busy each cycle; a negedge monitor pops and compares.
module tb_sram_nr1w;

  localparam int              DW   = 32;
  localparam int              SZ   = 100;
  localparam int              NRP  = 4;
  localparam int              BW   = 8;
  localparam int              NL   = DW / BW;
  localparam int              AW   = $clog2(SZ);
  localparam logic [DW-1:0]   INIT = 32'h5A5A_C3C3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_nr1w_if #(.DATA_WIDTH(DW), .SIZE(SZ), .NUM_READ_PORTS(NRP), .BYTE_WIDTH(BW)) bus ();

  sram_nr1w #(
    .DATA_WIDTH(DW), .SIZE(SZ), .NUM_READ_PORTS(NRP), .BYTE_WIDTH(BW), .INIT_VALUE(INIT)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    int            cyc;
    int            kind;   // 0: init_busy, 1: read_data[port]
    int            port;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            edge_cnt = 0;
  logic [DW-1:0] mem_m  [SZ];
  logic [DW-1:0] last_m [NRP];
  int            busy_left = 0;
  logic          dir_en = 1'b0;
  logic [DW-1:0] dir_val = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void check(string name, int port, logic [DW-1:0] got, logic [DW-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s port=%0d edge=%0d: got %h, expected %h", name, port, edge_cnt, got, want);
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.kind == 0) check("init_busy", 0, DW'(bus.init_busy), e.val);
        else             check("read_data", e.port, bus.read_data[e.port], e.val);
      end
    end
  end

  function automatic void push(int kind, int port, logic [DW-1:0] v);
    exp_t e;
    e.cyc  = edge_cnt + 1;
    e.kind = kind;
    e.port = port;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  function automatic logic [DW-1:0] merge_m(logic [DW-1:0] o, logic [DW-1:0] d, logic [NL-1:0] m);
    logic [DW-1:0] w;
    w = o;
    for (int b = 0; b < NL; b++) if (m[b]) w[b*BW +: BW] = d[b*BW +: BW];
    return w;
  endfunction

  function automatic void start_sweep();
    busy_left = SZ;
    for (int a = 0; a < SZ; a++) mem_m[a] = INIT;
  endfunction

  task automatic set_idle();
    bus.init_start    = 1'b0;
    bus.read_en       = '0;
    bus.read_addr     = '0;
    bus.write_en      = 1'b0;
    bus.write_byte_en = '0;
    bus.write_addr    = '0;
    bus.write_data    = '0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return AW'($urandom_range(SZ, (1 << AW) - 1));
    return AW'($urandom_range(0, SZ - 1));
  endfunction

  task automatic rand_req(int start_odds);
    bus.read_en = NRP'($urandom);
    for (int p = 0; p < NRP; p++) bus.read_addr[p] = pick_addr();
    bus.write_en      = 1'($urandom);
    bus.write_byte_en = NL'($urandom);
    bus.write_addr    = ($urandom_range(0, 3) == 0) ? bus.read_addr[0] : pick_addr();
    bus.write_data    = $urandom;
    bus.init_start    = (start_odds > 0) && ($urandom_range(1, start_odds) == 1);
  endtask

  // Predict the edge that follows the current inputs, then advance to just after it.
  task automatic cycle();
    logic [DW-1:0] v;
    int a, wa;
    if (busy_left > 0) begin
      for (int p = 0; p < NRP; p++) push(1, p, last_m[p]);
      busy_left--;
    end else begin
      wa = int'(bus.write_addr);
      for (int p = 0; p < NRP; p++) begin
        if (bus.read_en[p]) begin
          a = int'(bus.read_addr[p]);
          if (a >= SZ) v = '0;
          else begin
            v = mem_m[a];
`ifdef SRAM_NR1W_BYPASS_EN
            if (bus.write_en && wa == a) v = merge_m(v, bus.write_data, bus.write_byte_en);
`endif
          end
          last_m[p] = v;
        end
        push(1, p, last_m[p]);
      end
      if (bus.write_en && wa < SZ) mem_m[wa] = merge_m(mem_m[wa], bus.write_data, bus.write_byte_en);
      if (bus.init_start) start_sweep();
    end
    push(0, 0, DW'(busy_left > 0));
    if (dir_en) begin
      push(1, 0, dir_val);
      dir_en = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    set_idle();
    for (int p = 0; p < NRP; p++) last_m[p] = '0;
    start_sweep();
    #2;
    check("reset_init_busy", 0, DW'(bus.init_busy), DW'(1));
    for (int p = 0; p < NRP; p++) check("reset_read_data", p, bus.read_data[p], '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic read_all();
    set_idle();
    for (int a = 0; a < SZ; a++) begin
      bus.read_en = '1;
      for (int p = 0; p < NRP; p++) bus.read_addr[p] = AW'((a + p * 25) % SZ);
      cycle();
    end
  endtask

  task automatic wr(int addr, logic [DW-1:0] d, logic [NL-1:0] m);
    set_idle();
    bus.write_en      = 1'b1;
    bus.write_addr    = AW'(addr);
    bus.write_data    = d;
    bus.write_byte_en = m;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    do_reset();

    // Initial sweep: requests (including init_start) ignored; busy must fall after exactly SZ edges.
    for (int i = 0; i < SZ; i++) begin
      rand_req(4);
      cycle();
    end
    read_all();

    // Partial-lane write over an existing word.
    wr(5, 32'h1122_3344, 4'hF); cycle();
    wr(5, 32'hDEAD_BEEF, 4'b0101); cycle();
    set_idle(); bus.read_en[0] = 1'b1; bus.read_addr[0] = AW'(5);
    dir_en = 1'b1; dir_val = 32'h11AD_33EF; cycle();

    // All ports on the same addresses, one port occasionally idle and holding.
    wr(7, 32'hCAFE_F00D, 4'hF); cycle();
    wr(8, 32'h0123_4567, 4'hF); cycle();
    for (int i = 0; i < 6; i++) begin
      set_idle();
      bus.read_en = (i % 3 == 2) ? 4'b0111 : 4'b1111;
      for (int p = 0; p < NRP; p++) bus.read_addr[p] = AW'((i % 2) ? 8 : 7);
      if (i == 0) begin dir_en = 1'b1; dir_val = 32'hCAFE_F00D; end
      cycle();
    end

    // Same-cycle write and read of one address.
    wr(3, 32'h1234_5678, 4'hF); cycle();
    wr(3, 32'hAAAA_5555, 4'b1100); bus.read_en[0] = 1'b1; bus.read_addr[0] = AW'(3);
    dir_en = 1'b1;
`ifdef SRAM_NR1W_BYPASS_EN
    dir_val = 32'hAAAA_5678;
`else
    dir_val = 32'h1234_5678;
`endif
    cycle();
    set_idle(); bus.read_en[0] = 1'b1; bus.read_addr[0] = AW'(3);
    dir_en = 1'b1; dir_val = 32'hAAAA_5678; cycle();

    // Out-of-range write dropped, out-of-range reads return zero.
    wr(100, 32'hFFFF_FFFF, 4'hF); cycle();
    set_idle(); bus.read_en = 4'b0111;
    bus.read_addr[0] = AW'(127); bus.read_addr[1] = AW'(100); bus.read_addr[2] = AW'(99);
    dir_en = 1'b1; dir_val = '0; cycle();

    // Randomised traffic with rare clear requests.
    for (int i = 0; i < 300; i++) begin
      rand_req(120);
      cycle();
    end
    while (busy_left > 0) begin
      rand_req(0);
      cycle();
    end

    // Writes, clear request, reset at sweep cycle 50, full sweep again.
    for (int i = 0; i < 10; i++) begin
      wr(i * 9, $urandom, 4'hF);
      cycle();
    end
    set_idle(); bus.init_start = 1'b1; cycle();
    for (int i = 0; i < 49; i++) begin
      rand_req(2);
      cycle();
    end
    do_reset();
    for (int i = 0; i < SZ; i++) begin
      rand_req(3);
      cycle();
    end
    read_all();

    set_idle();
    cycle();
    cycle();
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) check("scoreboard_drain", 0, DW'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_nr1w.md
# sram_nr1w

Parametrised block SRAM with NUM_READ_PORTS synchronous read ports and one byte-enabled write port. It generalises the 2-read/1-write register-file and tag-array memory of the core: the read-port count and byte-lane width are parameters, and a built-in clear sequencer writes INIT_VALUE to every word after reset or on request. It sits under the register files, cache tag/valid arrays and other core structures that need a known initial state without an external clear loop.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of BYTE_WIDTH.
- SIZE, 1024: number of words; need not be a power of two.
- NUM_READ_PORTS, 2: number of independent read ports, 1..8.
- BYTE_WIDTH, 8: bits per write-enable lane; NUM_LANES = DATA_WIDTH/BYTE_WIDTH.
- INIT_VALUE, 0: value written to every word by the clear sequencer.
- ADDR_WIDTH, $clog2(SIZE): address width (derived).
- clk  in  1  sole clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; restarts the clear sweep.
- init_start  in  1  request a new clear sweep; pulse, sampled only in READY.
- init_busy  out  1  high while the clear sweep runs; all requests ignored.
- read_en  in  [NUM_READ_PORTS]  per-port read strobe.
- read_addr  in  [NUM_READ_PORTS][ADDR_WIDTH]  per-port read address.
- read_data  out  [NUM_READ_PORTS][DATA_WIDTH]  per-port registered read data.
- write_en  in  1  write strobe.
- write_byte_en  in  [NUM_LANES]  lane mask; lane i covers bits i*BYTE_WIDTH +: BYTE_WIDTH.
- write_addr  in  [ADDR_WIDTH]  write address.
- write_data  in  [DATA_WIDTH]  write data.

## Operation
- States: CLEAR, READY. Reset forces CLEAR with sweep counter 0.
- CLEAR: each cycle writes INIT_VALUE (all lanes) to word[counter], counter += 1; after writing SIZE-1 go to READY. init_busy = 1 throughout.
- CLEAR ignores write_en, read_en, init_start; read_data held at its current value.
- READY: init_start = 1 -> CLEAR next cycle, counter 0; a write or read in that same cycle is still performed.
- Write in READY: if write_en and write_addr < SIZE, lanes with write_byte_en = 1 updated; others unchanged. write_byte_en = 0 is a no-op.
- Read in READY: read_en[p] = 1 -> read_data[p] loads word[read_addr[p]] at next edge; read_en[p] = 0 -> read_data[p] holds.
- Out-of-range: write_addr >= SIZE dropped; read_addr >= SIZE loads 0.
- Ports independent; any number of ports may read the same address.
- Read of the address being written in the same cycle: see Configuration.

## Timing
- Reset values: read_data all 0; init_busy 1; state CLEAR; counter 0. Memory contents not reset by flops, only by the sweep.
- Sweep length exactly SIZE cycles; init_busy falls on the edge following the write of word SIZE-1; first accepted request in that cycle.
- Read latency 1 cycle; write visible to a read issued the following cycle.
- reset asserted mid-sweep or mid-operation: sweep restarts at 0 on deassertion; partial writes not guaranteed.
- init_start while init_busy: ignored, no sweep extension.

## Configuration
- SRAM_NR1W_BYPASS_EN defined: read of write_addr with write_en in the same READY cycle returns the merged word: write_data on enabled lanes, old contents on disabled lanes ("NEW_DATA").
- Not defined: same-cycle collision returns old contents (read-first); no comparator/mux logic generated.

## Structure
- Shared package sram_pkg: sram_init_state_t enum {CLEAR, READY}, lane-mask merge function, no per-instance constants.
- One sub-module: sram_clear_sequencer (state, counter, init_busy, mux of sweep vs. user write port); storage and read ports stay in sram_nr1w.

## Test plan
- Reset, SIZE=1024: init_busy high 1024 cycles after deassertion; then all 1024 words read INIT_VALUE on both ports.
- Write 0xDEADBEEF to addr 5, write_byte_en=4'b0101 over 0x11223344 -> next-cycle read returns 0x11AD33EF.
- NUM_READ_PORTS=4, all ports read addr 7 (0xCAFEF00D) and addr 8 alternately -> each port correct data 1 cycle later; read_en=0 port holds.
- Same-cycle write 0xAAAA5555 mask 4'b1100 to addr 3 (old 0x12345678) and read addr 3: 0xAAAA5678 with SRAM_NR1W_BYPASS_EN, 0x12345678 without.
- SIZE=100: writes to addr 100 dropped, read of addr 127 returns 0, sweep takes 100 cycles.
- init_start in READY after writes, reset pulsed at sweep cycle 50 -> sweep restarts, all words INIT_VALUE afterwards, requests during busy ignored.
